// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 constants, field widths and controller state type
//
// Purpose: common definitions for the sequential single-precision multiplier.
// Ports: none (package).
package fp_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;

  localparam int              FP_BIAS    = 127;
  localparam int              FP_EXP_MAX = 255;
  localparam logic [31:0]     FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MULT  = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational split of one binary32 operand into fields and class flags
//
// Purpose: decode sign/exponent/mantissa with hidden bit; exponent-0 inputs
// are flushed to zero (no subnormal support).
// Ports:
//   op      in  32  packed operand
//   sign    out 1   sign bit
//   exp     out 8   biased exponent
//   mant    out 24  mantissa with hidden 1 (0 when flushed)
//   is_zero out 1   exponent 0 (zero or flushed subnormal)
//   is_inf  out 1   exponent 255, fraction 0
//   is_nan  out 1   exponent 255, fraction non-zero
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [FRAC_W-1:0] frac;
  logic              exp_max;

  assign sign    = op[FRAC_W+EXP_W +: SIGN_W];
  assign exp     = op[FRAC_W +: EXP_W];
  assign frac    = op[FRAC_W-1:0];
  assign exp_max = (exp == EXP_W'(FP_EXP_MAX));
  assign is_zero = (exp == '0);
  assign is_inf  = exp_max && (frac == '0);
  assign is_nan  = exp_max && (frac != '0);
  assign mant    = is_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - multi-cycle binary32 multiplier with shift-add mantissa datapath
//
// Purpose: accept two operands, screen special values, multiply mantissas one
// multiplier bit per cycle, normalize, round/truncate and return the product.
// Optional feature macro: FP_MUL_RNE_EN (round-to-nearest-even; truncation otherwise).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   Float_num_A/B     32-bit operands
//   out_valid/out_ready result handshake (result held until accepted)
//   Float_result      32-bit packed product
//   busy              high in every state except IDLE
module fp_mul_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Float_num_A,
  input  logic [31:0] Float_num_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Float_result,
  output logic        busy
);

  localparam logic signed [9:0] E_MAX = 10'(FP_EXP_MAX);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;

  logic              sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma, mb;

  fp_unpack u_unpack_a (.op(a_q), .sign(sa), .exp(ea), .mant(ma),
                        .is_zero(za), .is_inf(ia), .is_nan(na));
  fp_unpack u_unpack_b (.op(b_q), .sign(sb), .exp(eb), .mant(mb),
                        .is_zero(zb), .is_inf(ib), .is_nan(nb));

  logic sign_r, nan_case, inf_case, zero_case;
  assign sign_r    = sa ^ sb;
  assign nan_case  = na || nb || (ia && zb) || (ib && za);
  assign inf_case  = ia || ib;
  assign zero_case = za || zb;

  // Normalization and packing of the accumulated product
  logic signed [9:0] e_norm;
  logic [FRAC_W-1:0] frac_n;
  logic [31:0]       norm_result;
`ifdef FP_MUL_RNE_EN
  logic guard, sticky, carry;
`endif

  always_comb begin
    e_norm = {2'b00, ea} + {2'b00, eb} - 10'(FP_BIAS);
    if (acc_q[PROD_W-1]) begin
      frac_n = acc_q[46:24];
      e_norm = e_norm + 10'sd1;
`ifdef FP_MUL_RNE_EN
      guard  = acc_q[23];
      sticky = |acc_q[22:0];
`endif
    end else begin
      frac_n = acc_q[45:23];
`ifdef FP_MUL_RNE_EN
      guard  = acc_q[22];
      sticky = |acc_q[21:0];
`endif
    end
`ifdef FP_MUL_RNE_EN
    carry = 1'b0;
    if (guard && (sticky || frac_n[0])) begin
      // Carry out of the fraction means mantissa rolled to 2.0: frac wraps to 0
      {carry, frac_n} = {1'b0, frac_n} + 24'd1;
    end
    if (carry) e_norm = e_norm + 10'sd1;
`endif
    if (e_norm >= E_MAX)       norm_result = {sign_r, 8'hFF, 23'd0};
    else if (e_norm <= 10'sd0) norm_result = {sign_r, 31'd0};
    else                       norm_result = {sign_r, e_norm[7:0], frac_n};
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CHECK;
      S_CHECK: state_d = (nan_case || inf_case || zero_case) ? S_OUT : S_MULT;
      S_MULT:  if (cnt_q == 5'd23) state_d = S_NORM;
      S_NORM:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = Float_num_A;
          b_d = Float_num_B;
        end
      end
      S_CHECK: begin
        if (nan_case)       result_d = FP_QNAN;
        else if (inf_case)  result_d = {sign_r, 8'hFF, 23'd0};
        else if (zero_case) result_d = {sign_r, 31'd0};
        else begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_MULT: begin
        if (mb[cnt_q]) acc_d = acc_q + ({24'd0, ma} << cnt_q);
        // Wrap to 0 so the counter idles at its reset value
        cnt_d = (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
      end
      S_NORM:  result_d = norm_result;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    out_valid    = (state_q == S_OUT);
    Float_result = result_q;
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - directed scoreboard bench for fp_mul_seq
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] Float_result;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  fp_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Float_num_A(op_a), .Float_num_B(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .Float_result(Float_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] fa, input logic [31:0] fb,
                        input logic [31:0] expected, input int exp_lat, input int hold);
    int lat;
    logic [31:0] want;
    logic [31:0] held;
    exp_q.push_back(expected);
    @(negedge clk);
    op_a = fa; op_b = fb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op_a = '0; op_b = '0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, " result"}, Float_result, want);
    held = Float_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold result"}, Float_result, want);
      check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " drain out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " drain in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, " drain busy"}, {31'd0, busy}, 32'd0);
    if (hold > 0) check({tag, " result kept"}, Float_result, held);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", Float_result, 32'd0);

    run_op("1.5x2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26, 0);
    run_op("-3x0.5", 32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 26, 0);
    run_op("infx0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0);
    run_op("nanx1", 32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 1, 0);
    run_op("infx-2", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1, 0);
    run_op("-0x3", 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1, 0);
    run_op("overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 26, 0);
    run_op("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 26, 0);
`ifdef FP_MUL_RNE_EN
    run_op("round", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 26, 0);
`else
    run_op("round", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 26, 0);
`endif
    run_op("backpressure", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26, 5);
    repeat (3) @(posedge clk);
    #1;
    check("no spurious op busy", {31'd0, busy}, 32'd0);

    // Abort mid-multiply with an asynchronous reset
    @(negedge clk);
    op_a = 32'h4040_0000; op_b = 32'h4040_0000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("mid busy before reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort result", Float_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort no result", {31'd0, out_valid}, 32'd0);
    run_op("after abort", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
